// File: rtl/stage_div.sv
// stage_div: radix-2 restoring 32-bit signed/unsigned divider, one quotient bit per cycle.
module stage_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t      state, state_d;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        sgn, sign1, sign2;
    logic [32:0] diff;
    logic [31:0] mag1, mag2, quo, rem;
    logic        launch;

    assign launch = start && !annul;
    assign mag1   = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    assign mag2   = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
    assign diff   = {1'b0, dividend[63:32]} - {1'b0, divisor};
    // Remainder accumulates in [64:33], quotient bits shift into [31:0].
    assign quo    = (sgn && (sign1 ^ sign2)) ? -dividend[31:0] : dividend[31:0];
    assign rem    = (sgn && sign1) ? -dividend[64:33] : dividend[64:33];
    assign ready  = state == END;
    assign result = ready ? {dividend[64:33], dividend[31:0]} : 64'd0;

    always_comb begin
        state_d = state;
        case (state)
            FREE:    state_d = launch ? ((opdata2 == 32'd0) ? BY_ZERO : ON) : FREE;
            BY_ZERO: state_d = annul ? FREE : END;
            ON:      state_d = annul ? FREE : ((cnt == 6'd32) ? END : ON);
            END:     state_d = start ? END : FREE;
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FREE;
        else      state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dividend <= '0;
            divisor  <= '0;
            cnt      <= '0;
            sgn      <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
        end else begin
            case (state)
                FREE: if (launch) begin
                    dividend <= {32'd0, mag1, 1'b0};
                    divisor  <= mag2;
                    cnt      <= '0;
                    sgn      <= signed_div;
                    sign1    <= opdata1[31];
                    sign2    <= opdata2[31];
                end
                BY_ZERO: dividend <= '0;
                ON: if (!annul) begin
                    if (cnt != 6'd32) begin
                        dividend <= diff[32] ? {dividend[63:0], 1'b0} : {diff[31:0], dividend[31:0], 1'b1};
                        cnt      <= cnt + 6'd1;
                    end else begin
                        dividend <= {rem, 1'b0, quo};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_div.sv
// tb_stage_div: directed vector and corner-sequence bench for stage_div.
module tb_stage_div;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    stage_div dut (
        .clk(clk), .rst(rst), .signed_div(signed_div), .opdata1(opdata1), .opdata2(opdata2),
        .start(start), .annul(annul), .result(result), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lmin;
        int          lmax;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic ok, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Returns the index k of the edge Ek after which ready is first seen, or -1 on timeout.
    task automatic wait_ready(output int e, output logic leak);
        e = -1;
        leak = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                e = i;
                break;
            end
            if (result != 64'd0) leak = 1'b1;
        end
    endtask

    task automatic run_op(input vec_t v);
        int   e;
        logic leak;
        @(negedge clk);
        signed_div = v.sd;
        opdata1 = v.a;
        opdata2 = v.b;
        start = 1'b1;
        wait_ready(e, leak);
        chk({v.name, " latency"}, e >= v.lmin && e <= v.lmax, 64'(e), 64'(v.lmax));
        chk({v.name, " result"}, result == v.exp, result, v.exp);
        chk({v.name, " zero before ready"}, !leak, 64'(leak), 64'd0);
        @(negedge clk);
        chk({v.name, " hold"}, ready && result == v.exp, result, v.exp);
        start = 1'b0;
        @(negedge clk);
        chk({v.name, " release"}, !ready && result == 64'd0, {63'd0, ready} | result, 64'd0);
    endtask

    initial begin
        int   e;
        logic leak;
        logic bad;
        vecs[0] = '{"udiv 100/7",      1'b0, 32'h64,       32'h7,        64'h00000002_0000000E, 33, 33};
        vecs[1] = '{"sdiv -7/2",       1'b1, 32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD, 33, 33};
        vecs[2] = '{"sdiv 7/-2",       1'b1, 32'h7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 33};
        vecs[3] = '{"udiv by zero",    1'b0, 32'h5,        32'h0,        64'h0,                 1,  2};
        vecs[4] = '{"sdiv by zero",    1'b1, 32'hFFFFFFFB, 32'h0,        64'h0,                 1,  2};
        vecs[5] = '{"sdiv overflow",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 33};
        vecs[6] = '{"udiv max/16",     1'b0, 32'hFFFFFFFF, 32'h10,       64'h0000000F_0FFFFFFF, 33, 33};
        vecs[7] = '{"udiv 2^31/max",   1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33, 33};
        vecs[8] = '{"sdiv -100/7",     1'b1, 32'hFFFFFF9C, 32'h7,        64'hFFFFFFFE_FFFFFFF2, 33, 33};
        vecs[9] = '{"udiv neg-bits/2", 1'b0, 32'hFFFFFFF9, 32'h2,        64'h00000001_7FFFFFFC, 33, 33};

        #12;
        chk("reset outputs", !ready && result == 64'd0, {63'd0, ready} | result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Annul sampled at E10 returns to FREE without ever raising ready.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'h64; opdata2 = 32'h7; start = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) bad = 1'b1;
        end
        annul = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            annul = 1'b0;
            if (ready || result != 64'd0) bad = 1'b1;
        end
        chk("annul no ready", !bad, 64'(bad), 64'd0);
        run_op(vecs[6]);

        // Asynchronous reset mid-division, then a clean operation.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'h64; opdata2 = 32'h7; start = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("reset mid-div", !ready && result == 64'd0, {63'd0, ready} | result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op('{"udiv 9/3 after reset", 1'b0, 32'h9, 32'h3, 64'h00000000_00000003, 33, 33});

        // Asynchronous reset while a result is being presented clears it between edges.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'h64; opdata2 = 32'h7; start = 1'b1;
        wait_ready(e, leak);
        chk("pre-reset result", result == 64'h00000002_0000000E, result, 64'h00000002_0000000E);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset in END", !ready && result == 64'd0, {63'd0, ready} | result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Operand changes and a start re-pulse during ON are ignored.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'h64; opdata2 = 32'h7; start = 1'b1;
        e = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                e = i;
                break;
            end
            if (i == 5) begin
                signed_div = 1'b1; opdata1 = 32'h9; opdata2 = 32'h0; start = 1'b0;
            end
            if (i == 6) start = 1'b1;
        end
        chk("ignore changes latency", e == 33, 64'(e), 64'd33);
        chk("ignore changes result", result == 64'h00000002_0000000E, result, 64'h00000002_0000000E);
        start = 1'b0;
        @(negedge clk);
        chk("ignore changes release", !ready && result == 64'd0, {63'd0, ready} | result, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
